// File: rtl/aes_uart_pkg.sv
// Shared types and constants for the AES block to UART byte sequencer.
package aes_uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM   = 2'd1,
      ST_FRAME = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_t;

   localparam int UART_MIN_FRAME_TICKS = 11;

   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;

   // Number of UART bytes emitted per block: raw bytes, or two hex chars per byte plus CR/LF.
   function automatic int seq_len(input int block_w, input bit ascii_en);
      if (ascii_en) begin
         return 2 * (block_w / 8) + 2;
      end
      return block_w / 8;
   endfunction

endpackage

// File: rtl/aes_uart_tx_seq_nibble_to_ascii.sv
// Combinational 4-bit value to upper-case ASCII hex character.
module nibble_to_ascii (
   input  logic [3:0] nibble,
   output logic [7:0] ascii
);

   assign ascii = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                   : (8'h37 + {4'h0, nibble});

endmodule

// File: rtl/aes_uart_tx_seq.sv
// Feeds a captured block to a baud-tick UART transmitter one byte per frame.
// Define AES_SEQ_ASCII_HEX_EN to send each byte as two ASCII hex chars followed by CR LF.
module aes_uart_tx_seq
   import aes_uart_pkg::*;
#(
   parameter int BLOCK_W     = 128,
   parameter int FRAME_TICKS = 11,
   parameter bit MSB_FIRST   = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               baud_tick,
   input  logic               blk_valid,
   input  logic [BLOCK_W-1:0] blk_data,
   output logic               blk_ready,
   output logic               tx_transmit,
   output logic [7:0]         tx_data,
   output logic               busy,
   output logic               done
);

`ifdef AES_SEQ_ASCII_HEX_EN
   localparam bit ASCII_EN = 1'b1;
`else
   localparam bit ASCII_EN = 1'b0;
`endif

   localparam int NB     = BLOCK_W / 8;
   localparam int N      = seq_len(BLOCK_W, ASCII_EN);
   localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
   localparam int BYTE_W = (NB > 1) ? $clog2(NB) : 1;
   localparam int TICK_W = $clog2(FRAME_TICKS);

   localparam logic [1:0] S_IDLE  = ST_IDLE;
   localparam logic [1:0] S_ARM   = ST_ARM;
   localparam logic [1:0] S_FRAME = ST_FRAME;
   localparam logic [1:0] S_DONE  = ST_DONE;

   if (FRAME_TICKS < UART_MIN_FRAME_TICKS || (BLOCK_W % 8) != 0) begin : g_param_check
      $fatal(1, "aes_uart_tx_seq: FRAME_TICKS must be >= 11 and BLOCK_W a multiple of 8");
   end

   logic [1:0]         state;
   logic [BLOCK_W-1:0] blk_in_ord;
   logic [BLOCK_W-1:0] blk_ord;
   logic [IDX_W-1:0]   byte_idx;
   logic [IDX_W-1:0]   sel_idx;
   logic [BYTE_W-1:0]  byte_sel;
   logic [7:0]         cur_byte;
   logic [7:0]         next_sym;
   logic [TICK_W-1:0]  tick_cnt;
   logic               last_sym;

   // Reorder at capture so byte 0 (first on the wire) always sits in bits [7:0].
   for (genvar gi = 0; gi < NB; gi++) begin : g_ord
      assign blk_in_ord[8*gi +: 8] = MSB_FIRST ? blk_data[BLOCK_W-1-8*gi -: 8]
                                               : blk_data[8*gi +: 8];
   end

   assign sel_idx  = (state == S_FRAME) ? (byte_idx + IDX_W'(1)) : byte_idx;
   assign cur_byte = blk_ord[{byte_sel, 3'b000} +: 8];
   assign last_sym = (byte_idx == IDX_W'(N - 1));

`ifdef AES_SEQ_ASCII_HEX_EN
   logic [3:0] nib;
   logic [7:0] hex_char;

   assign byte_sel = BYTE_W'(sel_idx >> 1);
   assign nib      = sel_idx[0] ? cur_byte[3:0] : cur_byte[7:4];

   nibble_to_ascii u_hex (
      .nibble (nib),
      .ascii  (hex_char)
   );

   always_comb begin
      next_sym = hex_char;
      if (sel_idx == IDX_W'(2 * NB)) begin
         next_sym = ASCII_CR;
      end else if (sel_idx == IDX_W'(2 * NB + 1)) begin
         next_sym = ASCII_LF;
      end
   end
`else
   assign byte_sel = BYTE_W'(sel_idx);
   assign next_sym = cur_byte;
`endif

   // Byte loads and tx_transmit edges happen only on baud ticks so a frame is never disturbed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         blk_ord     <= '0;
         byte_idx    <= '0;
         tick_cnt    <= '0;
         tx_transmit <= 1'b0;
         tx_data     <= 8'h00;
      end else begin
         case (state)
            S_IDLE: begin
               if (blk_valid) begin
                  blk_ord  <= blk_in_ord;
                  byte_idx <= '0;
                  state    <= S_ARM;
               end
            end
            S_ARM: begin
               if (baud_tick) begin
                  tx_data     <= next_sym;
                  tx_transmit <= 1'b1;
                  tick_cnt    <= '0;
                  state       <= S_FRAME;
               end
            end
            S_FRAME: begin
               if (baud_tick) begin
                  tx_transmit <= 1'b0;
                  if (tick_cnt == TICK_W'(FRAME_TICKS - 1)) begin
                     tick_cnt <= '0;
                     if (last_sym) begin
                        state <= S_DONE;
                     end else begin
                        byte_idx    <= byte_idx + IDX_W'(1);
                        tx_data     <= next_sym;
                        tx_transmit <= 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign blk_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);

endmodule

// File: tb/tb_aes_uart_tx_seq.sv
// Randomized self-checking bench: MSB-first and LSB-first sequencers side by side against a byte-list model.
module tb_aes_uart_tx_seq;

   localparam int BLOCK_W = 128;
   localparam int FT      = 11;
   localparam int NB      = BLOCK_W / 8;
`ifdef AES_SEQ_ASCII_HEX_EN
   localparam bit ASCII = 1'b1;
`else
   localparam bit ASCII = 1'b0;
`endif
   localparam int NSYM   = ASCII ? (2 * NB + 2) : NB;
   localparam int BUDGET = (NSYM + 2) * FT * 8 + 200;

   typedef logic [7:0] bq_t [$];

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               baud_tick = 1'b0;
   logic               blk_valid = 1'b0;
   logic [BLOCK_W-1:0] blk_data = '0;
   logic [1:0]         rdy, tr, bsy, dn;
   logic [7:0]         dat [2];

   int n_checks = 0;
   int n_fail = 0;

   aes_uart_tx_seq #(.BLOCK_W(BLOCK_W), .FRAME_TICKS(FT), .MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .blk_valid(blk_valid), .blk_data(blk_data),
      .blk_ready(rdy[0]), .tx_transmit(tr[0]), .tx_data(dat[0]), .busy(bsy[0]), .done(dn[0]));

   aes_uart_tx_seq #(.BLOCK_W(BLOCK_W), .FRAME_TICKS(FT), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .blk_valid(blk_valid), .blk_data(blk_data),
      .blk_ready(rdy[1]), .tx_transmit(tr[1]), .tx_data(dat[1]), .busy(bsy[1]), .done(dn[1]));

   always #10 clk = ~clk;

   int baud_div = 4;
   bit baud_auto = 1'b1;
   int div_cnt = 0;

   always @(negedge clk) begin
      if (baud_auto) begin
         baud_tick = (div_cnt == 0);
         div_cnt   = (div_cnt + 1) % baud_div;
      end
   end

   // Monitor: logs each tx_transmit rising edge with its byte and cycle, plus done pulses.
   int         cyc = 0;
   bq_t        q [2];
   int         lc [2][$];
   int         done_cnt [2];
   int         done_wide [2];
   int         done_cyc [2];
   int         viol = 0;
   logic [1:0] p_tr = '0;
   logic [1:0] p_dn = '0;
   logic [7:0] p_dat [2];

   always @(posedge clk) begin
      bit t;
      t = baud_tick;
      cyc++;
      #1;
      if (!rst_n) begin
         p_tr = '0;
         p_dn = '0;
         p_dat[0] = 8'h00;
         p_dat[1] = 8'h00;
      end else begin
         for (int d = 0; d < 2; d++) begin
            if ((tr[d] !== p_tr[d] || dat[d] !== p_dat[d]) && !t) viol++;
            if (tr[d] && !p_tr[d]) begin
               q[d].push_back(dat[d]);
               lc[d].push_back(cyc);
            end
            if (dn[d]) begin
               if (p_dn[d]) done_wide[d]++;
               else begin
                  done_cnt[d]++;
                  done_cyc[d] = cyc;
               end
            end
            p_tr[d]  = tr[d];
            p_dn[d]  = dn[d];
            p_dat[d] = dat[d];
         end
      end
   end

   function automatic bq_t model(input logic [BLOCK_W-1:0] blk, input bit msb);
      bq_t        r;
      logic [7:0] b;
      logic [3:0] n;
      int         sh;
      for (int k = 0; k < NB; k++) begin
         sh = msb ? (NB - 1 - k) * 8 : k * 8;
         b  = 8'(blk >> sh);
         if (ASCII) begin
            for (int h = 0; h < 2; h++) begin
               n = (h == 0) ? b[7:4] : b[3:0];
               r.push_back((n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10));
            end
         end else begin
            r.push_back(b);
         end
      end
      if (ASCII) begin
         r.push_back(8'h0D);
         r.push_back(8'h0A);
      end
      return r;
   endfunction

   function automatic logic [BLOCK_W-1:0] rand_blk();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic clear_mon();
      for (int d = 0; d < 2; d++) begin
         q[d].delete();
         lc[d].delete();
         done_cnt[d]  = 0;
         done_wide[d] = 0;
         done_cyc[d]  = 0;
      end
      viol = 0;
   endtask

   task automatic wait_done(output bit to);
      to = 1'b1;
      for (int i = 0; i < BUDGET; i++) begin
         if (done_cnt[0] > 0 && done_cnt[1] > 0) begin
            to = 1'b0;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic offer(input logic [BLOCK_W-1:0] blk);
      @(negedge clk);
      blk_data  = blk;
      blk_valid = 1'b1;
      @(negedge clk);
      blk_valid = 1'b0;
      blk_data  = rand_blk();
   endtask

   task automatic run_block(input logic [BLOCK_W-1:0] blk, output bit to);
      clear_mon();
      offer(blk);
      wait_done(to);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (rdy[d] !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready dut%0d: got %b want 1", d, rdy[d]); end
         n_checks++;
         if (tr[d] !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_transmit dut%0d: got %b want 0", d, tr[d]); end
         n_checks++;
         if (dat[d] !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_data dut%0d: got %h want 00", d, dat[d]); end
         n_checks++;
         if (bsy[d] !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy dut%0d: got %b want 0", d, bsy[d]); end
         n_checks++;
         if (dn[d] !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done dut%0d: got %b want 0", d, dn[d]); end
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_fixed_block();
      logic [BLOCK_W-1:0] blk;
      bq_t                exp;
      bit                 to;
      blk = 128'h00112233445566778899AABBCCDDEEFF;
      run_block(blk, to);
      n_checks++;
      if (to) begin n_fail++; $display("[TB] FAIL fixed_timeout: got no done, want done within %0d cycles", BUDGET); end
      n_checks++;
      if (viol !== 0) begin n_fail++; $display("[TB] FAIL fixed_off_tick_change: got %0d, want 0", viol); end
      for (int d = 0; d < 2; d++) begin
         exp = model(blk, d == 0);
         n_checks++;
         if (q[d].size() !== NSYM) begin
            n_fail++; $display("[TB] FAIL fixed_count dut%0d: got %0d want %0d", d, q[d].size(), NSYM);
         end else begin
            for (int k = 0; k < NSYM; k++) begin
               n_checks++;
               if (q[d][k] !== exp[k]) begin n_fail++; $display("[TB] FAIL fixed_byte dut%0d[%0d]: got %h want %h", d, k, q[d][k], exp[k]); end
            end
            for (int k = 1; k < NSYM; k++) begin
               n_checks++;
               if (lc[d][k] - lc[d][k-1] !== FT * baud_div) begin
                  n_fail++; $display("[TB] FAIL fixed_spacing dut%0d[%0d]: got %0d want %0d", d, k, lc[d][k] - lc[d][k-1], FT * baud_div);
               end
            end
            n_checks++;
            if (done_cyc[d] - lc[d][NSYM-1] !== FT * baud_div) begin
               n_fail++; $display("[TB] FAIL fixed_done_latency dut%0d: got %0d want %0d", d, done_cyc[d] - lc[d][NSYM-1], FT * baud_div);
            end
         end
         n_checks++;
         if (done_cnt[d] !== 1) begin n_fail++; $display("[TB] FAIL fixed_done_count dut%0d: got %0d want 1", d, done_cnt[d]); end
         n_checks++;
         if (done_wide[d] !== 0) begin n_fail++; $display("[TB] FAIL fixed_done_width dut%0d: got %0d extra cycles want 0", d, done_wide[d]); end
         n_checks++;
         if (rdy[d] !== 1'b1 || bsy[d] !== 1'b0) begin
            n_fail++; $display("[TB] FAIL fixed_idle_after dut%0d: got ready=%b busy=%b want 1/0", d, rdy[d], bsy[d]);
         end
      end
   endtask

   task automatic test_random_blocks();
      logic [BLOCK_W-1:0] blk;
      bq_t                exp;
      bit                 to;
      for (int r = 0; r < 3; r++) begin
         baud_div = 4 + r;
         blk = rand_blk();
         run_block(blk, to);
         n_checks++;
         if (to) begin n_fail++; $display("[TB] FAIL random_timeout run%0d: got no done, want done", r); end
         n_checks++;
         if (viol !== 0) begin n_fail++; $display("[TB] FAIL random_off_tick_change run%0d: got %0d want 0", r, viol); end
         for (int d = 0; d < 2; d++) begin
            exp = model(blk, d == 0);
            n_checks++;
            if (q[d] != exp) begin
               n_fail++; $display("[TB] FAIL random_seq run%0d dut%0d: got %0d bytes (first %h) want %0d bytes (first %h)",
                                  r, d, q[d].size(), (q[d].size() > 0) ? q[d][0] : 8'hxx, exp.size(), exp[0]);
            end
            if (q[d].size() > 1) begin
               n_checks++;
               if (lc[d][1] - lc[d][0] !== FT * baud_div) begin
                  n_fail++; $display("[TB] FAIL random_spacing run%0d dut%0d: got %0d want %0d", r, d, lc[d][1] - lc[d][0], FT * baud_div);
               end
            end
         end
      end
      baud_div = 4;
   endtask

   task automatic test_busy_ignore();
      logic [BLOCK_W-1:0] blk_a, blk_b;
      bq_t                exp;
      bit                 to;
      bit                 reached;
      blk_a = rand_blk();
      blk_b = rand_blk();
      clear_mon();
      offer(blk_a);
      reached = 1'b0;
      for (int i = 0; i < BUDGET; i++) begin
         if (q[0].size() >= 3) begin reached = 1'b1; break; end
         @(negedge clk);
      end
      n_checks++;
      if (!reached) begin n_fail++; $display("[TB] FAIL busy_wait_third_byte: got %0d bytes want 3", q[0].size()); end
      @(negedge clk);
      blk_data  = blk_b;
      blk_valid = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (rdy[d] !== 1'b0 || bsy[d] !== 1'b1) begin
            n_fail++; $display("[TB] FAIL busy_ready_low dut%0d: got ready=%b busy=%b want 0/1", d, rdy[d], bsy[d]);
         end
      end
      repeat (3) @(negedge clk);
      blk_valid = 1'b0;
      wait_done(to);
      n_checks++;
      if (to) begin n_fail++; $display("[TB] FAIL busy_timeout: got no done, want done"); end
      for (int d = 0; d < 2; d++) begin
         exp = model(blk_a, d == 0);
         n_checks++;
         if (q[d] != exp) begin n_fail++; $display("[TB] FAIL busy_first_block dut%0d: got %0d bytes want %0d intact bytes of block A", d, q[d].size(), exp.size()); end
         n_checks++;
         if (done_cnt[d] !== 1) begin n_fail++; $display("[TB] FAIL busy_done_count dut%0d: got %0d want 1", d, done_cnt[d]); end
      end
      run_block(blk_b, to);
      n_checks++;
      if (to) begin n_fail++; $display("[TB] FAIL busy_second_timeout: got no done, want done"); end
      for (int d = 0; d < 2; d++) begin
         exp = model(blk_b, d == 0);
         n_checks++;
         if (q[d] != exp) begin n_fail++; $display("[TB] FAIL busy_second_block dut%0d: got %0d bytes want %0d bytes of block B", d, q[d].size(), exp.size()); end
      end
   endtask

   task automatic test_tick_capture();
      logic [BLOCK_W-1:0] blk;
      bq_t                exp;
      bit                 to;
      blk = rand_blk();
      @(posedge clk);
      baud_auto = 1'b0;
      clear_mon();
      @(negedge clk);
      baud_tick = 1'b0;
      @(negedge clk);
      blk_data  = blk;
      blk_valid = 1'b1;
      baud_tick = 1'b1;
      @(negedge clk);
      blk_valid = 1'b0;
      baud_tick = 1'b0;
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (tr[d] !== 1'b0 || bsy[d] !== 1'b1) begin
            n_fail++; $display("[TB] FAIL capture_tick_ignored dut%0d: got transmit=%b busy=%b want 0/1", d, tr[d], bsy[d]);
         end
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (tr[d] !== 1'b0) begin n_fail++; $display("[TB] FAIL capture_arm_wait dut%0d: got transmit=%b want 0", d, tr[d]); end
      end
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
      for (int d = 0; d < 2; d++) begin
         exp = model(blk, d == 0);
         n_checks++;
         if (tr[d] !== 1'b1 || dat[d] !== exp[0]) begin
            n_fail++; $display("[TB] FAIL capture_first_load dut%0d: got transmit=%b data=%h want 1/%h", d, tr[d], dat[d], exp[0]);
         end
      end
      @(posedge clk);
      div_cnt   = 2;
      baud_auto = 1'b1;
      wait_done(to);
      n_checks++;
      if (to) begin n_fail++; $display("[TB] FAIL capture_timeout: got no done, want done"); end
      for (int d = 0; d < 2; d++) begin
         exp = model(blk, d == 0);
         n_checks++;
         if (q[d] != exp) begin n_fail++; $display("[TB] FAIL capture_seq dut%0d: got %0d bytes want %0d", d, q[d].size(), exp.size()); end
      end
   endtask

   task automatic test_reset_mid_block();
      logic [BLOCK_W-1:0] blk;
      bq_t                exp;
      bit                 to;
      bit                 reached;
      blk = rand_blk();
      clear_mon();
      offer(blk);
      reached = 1'b0;
      for (int i = 0; i < BUDGET; i++) begin
         if (q[0].size() >= 5) begin reached = 1'b1; break; end
         @(negedge clk);
      end
      n_checks++;
      if (!reached) begin n_fail++; $display("[TB] FAIL midreset_wait_byte5: got %0d bytes want 5", q[0].size()); end
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (rdy[d] !== 1'b1 || tr[d] !== 1'b0 || dat[d] !== 8'h00 || bsy[d] !== 1'b0 || dn[d] !== 1'b0) begin
            n_fail++; $display("[TB] FAIL midreset_outputs dut%0d: got ready=%b transmit=%b data=%h busy=%b done=%b want 1/0/00/0/0",
                               d, rdy[d], tr[d], dat[d], bsy[d], dn[d]);
         end
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (rdy[d] !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_ready_after dut%0d: got %b want 1", d, rdy[d]); end
      end
      blk = rand_blk();
      run_block(blk, to);
      n_checks++;
      if (to) begin n_fail++; $display("[TB] FAIL midreset_timeout: got no done, want done"); end
      for (int d = 0; d < 2; d++) begin
         exp = model(blk, d == 0);
         n_checks++;
         if (q[d] != exp) begin
            n_fail++; $display("[TB] FAIL midreset_new_block dut%0d: got %0d bytes (first %h) want %0d (first %h)",
                               d, q[d].size(), (q[d].size() > 0) ? q[d][0] : 8'hxx, exp.size(), exp[0]);
         end
      end
   endtask

   initial begin
      p_dat[0] = 8'h00;
      p_dat[1] = 8'h00;
      test_reset();
      test_fixed_block();
      test_random_blocks();
      test_busy_ignore();
      test_tick_capture();
      test_reset_mid_block();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
